// File: rtl/ld_echo_pkg.sv
// Shared types and helpers for the laser-diode echo capture block.
// LD_ECHO_FRAME_ID_EN widens each buffered word with a per-window frame id.
package ld_echo_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

`ifdef LD_ECHO_FRAME_ID_EN
  localparam bit FRAME_ID_EN = 1'b1;
`else
  localparam bit FRAME_ID_EN = 1'b0;
`endif

  // Buffered word is {frame_id (optional), last, data}.
  function automatic int fifo_word_w(input int data_w, input int cnt_w);
    return data_w + 1 + (FRAME_ID_EN ? cnt_w : 0);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; dout shows the head word whenever !empty.
// Writes while full are ignored; full is judged before any same-cycle read.
module sync_fifo_fwft #(
  parameter int WIDTH = 17,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ld_echo_capture.sv
// Opens a fixed-length ADC capture window a fixed delay after each LD start edge and
// streams the window out of a FWFT FIFO. LD_ECHO_FRAME_ID_EN adds the m_frame_id port.
//
// state   | meaning
// IDLE    | waiting for a start rising edge
// DELAY   | counting down the start-to-capture delay
// CAPTURE | writing WIN_LEN valid ADC samples into the FIFO
module ld_echo_capture
  import ld_echo_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int DELAY_CYC = 20,
  parameter int WIN_LEN   = 256,
  parameter int FIFO_AW   = 9,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              ovf,
  output logic [CNT_W-1:0]  missed_cnt
`ifdef LD_ECHO_FRAME_ID_EN
  ,
  output logic [CNT_W-1:0]  m_frame_id
`endif
);

  localparam int WORD_W = fifo_word_w(DATA_W, CNT_W);
  localparam int DLY_W  = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;
  localparam int SMP_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(DELAY_CYC - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(WIN_LEN - 1);

  state_t             state;
  logic               start_q;
  logic               start_re;
  logic [DLY_W-1:0]   dly_cnt;
  logic [SMP_W-1:0]   smp_cnt;
  logic               win_last;
  logic               wr_en;
  logic               rd_en;
  logic               fifo_full;
  logic               fifo_empty;
  logic [WORD_W-1:0]  fifo_din;
  logic [WORD_W-1:0]  fifo_dout;

  assign start_re = start & ~start_q;
  assign win_last = (smp_cnt == SMP_LAST);
  assign wr_en    = (state == CAPTURE) && adc_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_q <= 1'b0;
    else        start_q <= start;
  end

  // Delay is a down-counter loaded so that it expires DELAY_CYC edges after the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dly_cnt <= '0;
      smp_cnt <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_re) begin
            state   <= DELAY;
            dly_cnt <= DLY_LOAD;
            busy    <= 1'b1;
          end
        end
        DELAY: begin
          if (dly_cnt == '0) begin
            state   <= CAPTURE;
            smp_cnt <= '0;
          end else begin
            dly_cnt <= dly_cnt - 1'b1;
          end
        end
        CAPTURE: begin
          if (adc_valid) begin
            smp_cnt <= smp_cnt + 1'b1;
            if (win_last) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf        <= 1'b0;
      missed_cnt <= '0;
    end else begin
      if (wr_en && fifo_full) ovf <= 1'b1;
      if (start_re && (state != IDLE) && (missed_cnt != '1))
        missed_cnt <= missed_cnt + CNT_W'(1);
    end
  end

`ifdef LD_ECHO_FRAME_ID_EN
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] win_frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      win_frame <= '0;
    end else if ((state == IDLE) && start_re) begin
      win_frame <= frame_cnt;
      frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  assign fifo_din   = {win_frame, win_last, adc_data};
  assign m_frame_id = fifo_empty ? '0 : fifo_dout[DATA_W+1 +: CNT_W];
`else
  assign fifo_din = {win_last, adc_data};
`endif

  sync_fifo_fwft #(
    .WIDTH (WORD_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .din   (fifo_din),
    .full  (fifo_full),
    .rd_en (rd_en),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  // Head word is masked while empty so outputs read zero out of reset.
  assign m_valid = !fifo_empty;
  assign rd_en   = m_valid && m_ready;
  assign m_data  = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
  assign m_last  = !fifo_empty && fifo_dout[DATA_W];

endmodule

// File: tb/tb_ld_echo_capture.sv
// Randomized scoreboard bench for ld_echo_capture (small FIFO so windows can overflow).
module tb_ld_echo_capture;

  localparam int DATA_W    = 16;
  localparam int DELAY_CYC = 20;
  localparam int WIN_LEN   = 12;
  localparam int FIFO_AW   = 3;
  localparam int CNT_W     = 16;
  localparam int DEPTH     = 1 << FIFO_AW;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
`ifdef LD_ECHO_FRAME_ID_EN
  localparam bit FID = 1'b1;
`else
  localparam bit FID = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              adc_valid = 1'b0;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_last;
  logic              busy;
  logic              ovf;
  logic [CNT_W-1:0]  missed_cnt;
`ifdef LD_ECHO_FRAME_ID_EN
  logic [CNT_W-1:0]  m_frame_id;
`endif

  always #5 clk = ~clk;

  ld_echo_capture #(
    .DATA_W(DATA_W), .DELAY_CYC(DELAY_CYC), .WIN_LEN(WIN_LEN),
    .FIFO_AW(FIFO_AW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .adc_data(adc_data), .adc_valid(adc_valid),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .ovf(ovf), .missed_cnt(missed_cnt)
`ifdef LD_ECHO_FRAME_ID_EN
    , .m_frame_id(m_frame_id)
`endif
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Window k opens DELAY_CYC+1 edges after its accepted start edge and takes the next
  // WIN_LEN valid samples; the FIFO is tracked only as an occupancy count.
  logic [63:0] sb[$];
  int     occ = 0;
  bit     mdl_busy = 0;
  bit     mdl_ovf = 0;
  int     mdl_missed = 0;
  bit     st_prev = 0;
  longint edge_n = 0;
  longint open_edge = 0;
  int     idx = 0;
  int     frame_nxt = 0;
  int     cur_frame = 0;

  always @(posedge clk) begin
    bit rise, was_busy, do_push, do_pop, last;
    logic [63:0] w;
    if (!rst_n) begin
      occ = 0; mdl_busy = 0; mdl_ovf = 0; mdl_missed = 0; st_prev = 0;
      edge_n = 0; idx = 0; frame_nxt = 0; cur_frame = 0;
      sb.delete();
    end else begin
      edge_n++;
      rise = start && !st_prev;
      st_prev = start;
      was_busy = mdl_busy;
      do_pop = m_ready && (occ > 0);
      do_push = 0;
      if (was_busy && edge_n >= open_edge && adc_valid) begin
        last = (idx == WIN_LEN - 1);
        if (occ < DEPTH) begin
          do_push = 1;
          w = '0;
          w[DATA_W-1:0] = adc_data;
          w[DATA_W] = last;
          if (FID) w[DATA_W+1 +: CNT_W] = CNT_W'(cur_frame);
          sb.push_back(w);
        end else begin
          mdl_ovf = 1;
        end
        idx++;
        if (last) mdl_busy = 0;
      end
      if (rise) begin
        if (was_busy) begin
          if (mdl_missed < CNT_MAX) mdl_missed++;
        end else begin
          mdl_busy = 1;
          open_edge = edge_n + DELAY_CYC + 1;
          idx = 0;
          cur_frame = frame_nxt;
          frame_nxt++;
        end
      end
      occ = occ + int'(do_push) - int'(do_pop);
    end
  end

  // ---------------- input drivers ----------------
  int vmode = 0;  // 0: always valid, 1: toggling, 2: random
  int rmode = 0;  // 0: always ready, 1: never ready, 2: random
  bit vtog = 0;

  initial begin
    forever begin
      @(negedge clk);
      adc_data = DATA_W'($urandom);
      vtog = !vtog;
      case (vmode)
        0: adc_valid = 1'b1;
        1: adc_valid = vtog;
        default: adc_valid = 1'($urandom_range(0, 1));
      endcase
      case (rmode)
        0: m_ready = 1'b1;
        1: m_ready = 1'b0;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic [DATA_W:0] prev_word = '0;
  bit prev_stall = 0;

  initial begin
    logic [63:0] act, exp;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        chk("m_valid", m_valid, occ > 0);
        chk("busy", busy, mdl_busy);
        chk("ovf", ovf, mdl_ovf);
        chk("missed_cnt", missed_cnt, mdl_missed);
        if (prev_stall && m_valid) chk("stall_hold", {m_last, m_data}, prev_word);
        if (m_valid && m_ready) begin
          act = '0;
          act[DATA_W-1:0] = m_data;
          act[DATA_W] = m_last;
`ifdef LD_ECHO_FRAME_ID_EN
          act[DATA_W+1 +: CNT_W] = m_frame_id;
`endif
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_word: got %0h expected none (t=%0t)", act, $time);
          end else begin
            exp = sb.pop_front();
            chk("word", act, exp);
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_word  = {m_last, m_data};
      end
    end
  end

  // ---------------- sequence ----------------
  task automatic check_reset_vals(input string tag);
    chk({tag, " m_valid"}, m_valid, 0);
    chk({tag, " m_last"}, m_last, 0);
    chk({tag, " m_data"}, m_data, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " ovf"}, ovf, 0);
    chk({tag, " missed_cnt"}, missed_cnt, 0);
  endtask

  task automatic pulse(input int width);
    @(negedge clk);
    start = 1'b1;
    repeat (width) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    bit done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      #3;
      done = !mdl_busy && (occ == 0) && (sb.size() == 0) && !start;
    end
    chk({tag, " drained"}, done, 1);
  endtask

  initial begin
    int n;
    #2;
    check_reset_vals("reset");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // full-rate window, long start pulse
    vmode = 0; rmode = 0;
    pulse(6);
    wait_idle("basic", 200);

    // adc_valid toggling
    vmode = 1;
    pulse(3);
    wait_idle("toggle", 200);

    // starts during DELAY and during CAPTURE are ignored and counted
    vmode = 0;
    pulse(2);
    repeat (5) @(negedge clk);
    pulse(3);
    repeat (14) @(negedge clk);
    pulse(1);
    wait_idle("missed", 200);
    chk("missed_total", missed_cnt, 2);

    // downstream stalled: FIFO fills, tail of window dropped
    rmode = 1;
    pulse(5);
    repeat (45) @(negedge clk);
    #2;
    chk("stall m_valid", m_valid, 1);
    chk("stall ovf", ovf, 1);
    rmode = 0;
    wait_idle("overflow", 200);

    // random valid / ready
    vmode = 2; rmode = 2;
    repeat (6) begin
      pulse($urandom_range(1, 8));
      repeat ($urandom_range(45, 70)) @(negedge clk);
    end
    rmode = 0;
    wait_idle("random", 400);

    // reset after four samples of a window have been written
    vmode = 0; rmode = 1;
    pulse(2);
    n = 0;
    while (!(mdl_busy && idx == 4) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach smp 4", n < 200, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    vmode = 1; rmode = 2;
    pulse(3);
    repeat (60) @(negedge clk);
    rmode = 0;
    wait_idle("post_reset", 200);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
